// File: rtl/idma_burst_splitter.sv
// idma_burst_splitter: read-side burst legalizer.
// Takes one 1D transfer and issues a sequence of bursts. No burst crosses a page
// boundary, exceeds the per-protocol beat limit, or exceeds the optional log-length cap.
// A zero-length request produces a one-cycle BACKEND error pulse and no burst.
// Optional feature: define IDMA_BURST_SPLITTER_STATS_EN to add saturating
// counters for burst handshakes and error pulses.
//
// state   | meaning
// IDLE    | ready for a new transfer request
// SPLIT   | presenting bursts of the registered transfer
module idma_burst_splitter #(
  parameter int AddrWidth  = 64,
  parameter int DataWidth  = 64,
  parameter int TFLenWidth = 32,
  parameter int PageSize   = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic [TFLenWidth-1:0] req_length_i,
  input  logic [1:0]            req_protocol_i,
  input  logic [2:0]            req_max_llen_i,
  input  logic                  req_reduce_len_i,
  output logic                  burst_valid_o,
  input  logic                  burst_ready_i,
  output logic [AddrWidth-1:0]  burst_addr_o,
  output logic [7:0]            burst_len_o,
  output logic [TFLenWidth-1:0] burst_bytes_o,
  output logic                  burst_first_o,
  output logic                  burst_last_o,
  output logic                  err_valid_o,
  output logic [1:0]            err_type_o,
  output logic                  busy_o
`ifdef IDMA_BURST_SPLITTER_STATS_EN
  ,
  output logic [31:0]           stat_bursts_o,
  output logic [15:0]           stat_errors_o
`endif
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int OffBits   = $clog2(StrbWidth);

  // Internal arithmetic width: wide enough for remaining length, the largest
  // beat capacity (256 beats) and a full page, so no intermediate value overflows.
  localparam int CwLen  = TFLenWidth + 1;
  localparam int CwBeat = $clog2(256 * StrbWidth) + 2;
  localparam int CwPage = $clog2(PageSize) + 2;
  localparam int CwA    = (CwLen > CwBeat) ? CwLen : CwBeat;
  localparam int CW     = (CwA > CwPage) ? CwA : CwPage;

  localparam logic [1:0] PROT_AXI = 2'd0;
  localparam logic [1:0] ERR_BACKEND = 2'b10;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SPLIT = 1'b1;

  logic [0:0]            state_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [TFLenWidth-1:0] rem_q;
  logic [1:0]            prot_q;
  logic [2:0]            llen_q;
  logic                  reduce_q;
  logic                  first_q;
  logic                  err_q;

  logic [CW-1:0] off;
  logic [CW-1:0] page_off;
  logic [CW-1:0] max_beats;
  logic [CW-1:0] cap_beat;
  logic [CW-1:0] cap_page;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] bytes;
  logic [CW-1:0] beats_m1;
  logic          split;
  logic          is_last;
  logic          req_hs;
  logic          burst_hs;

  assign split    = (state_q == S_SPLIT);
  assign req_hs   = req_valid_i & req_ready_o;
  assign burst_hs = burst_valid_o & burst_ready_i;

  // Burst size for the current position: the tightest of remaining bytes,
  // beat capacity and distance to the next page boundary.
  always_comb begin
    off      = CW'(addr_q & AddrWidth'(StrbWidth - 1));
    page_off = CW'(addr_q & AddrWidth'(PageSize - 1));
    rem_w    = CW'(rem_q);
    if (prot_q == PROT_AXI) begin
      // 1<<llen is at most 128, so the cap is always below the AXI limit of 256
      if (reduce_q) max_beats = CW'(1) << llen_q;
      else          max_beats = CW'(256);
    end else begin
      max_beats = CW'(1);
    end
    cap_beat = max_beats * CW'(StrbWidth) - off;
    cap_page = CW'(PageSize) - page_off;
    bytes    = rem_w;
    if (cap_beat < bytes) bytes = cap_beat;
    if (cap_page < bytes) bytes = cap_page;
    beats_m1 = (off + bytes - CW'(1)) >> OffBits;
    is_last  = (bytes == rem_w);
  end

  assign req_ready_o   = ~split;
  assign busy_o        = split;
  assign burst_valid_o = split;
  assign burst_addr_o  = addr_q;
  assign burst_len_o   = split ? beats_m1[7:0] : 8'd0;
  assign burst_bytes_o = split ? bytes[TFLenWidth-1:0] : '0;
  assign burst_first_o = split & first_q;
  assign burst_last_o  = split & is_last;
  assign err_valid_o   = err_q;
  assign err_type_o    = err_q ? ERR_BACKEND : 2'b00;

  // Transfer FSM: register a request, then walk it forward one burst per handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      prot_q   <= '0;
      llen_q   <= '0;
      reduce_q <= 1'b0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_hs) begin
            if (req_length_i == '0) begin
              err_q <= 1'b1;
            end else begin
              addr_q   <= req_addr_i;
              rem_q    <= req_length_i;
              prot_q   <= req_protocol_i;
              llen_q   <= req_max_llen_i;
              reduce_q <= req_reduce_len_i;
              first_q  <= 1'b1;
              state_q  <= S_SPLIT;
            end
          end
        end
        default: begin
          if (burst_hs) begin
            addr_q  <= addr_q + AddrWidth'(bytes);
            rem_q   <= rem_q - bytes[TFLenWidth-1:0];
            first_q <= 1'b0;
            if (is_last) state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef IDMA_BURST_SPLITTER_STATS_EN
  logic [31:0] stat_bursts_q;
  logic [15:0] stat_errors_q;

  // Saturating event counters for bursts issued and errors reported.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_bursts_q <= '0;
      stat_errors_q <= '0;
    end else begin
      if (burst_hs && (stat_bursts_q != '1)) stat_bursts_q <= stat_bursts_q + 32'd1;
      if (err_q && (stat_errors_q != '1))    stat_errors_q <= stat_errors_q + 16'd1;
    end
  end

  assign stat_bursts_o = stat_bursts_q;
  assign stat_errors_o = stat_errors_q;
`endif

endmodule

// File: tb/tb_idma_burst_splitter.sv
// Testbench for idma_burst_splitter (default build, DataWidth=64, PageSize=4096).
module tb_idma_burst_splitter;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [31:0] bytes;
    logic        first;
    logic        last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [31:0] req_length = '0;
  logic [1:0]  req_protocol = '0;
  logic [2:0]  req_max_llen = '0;
  logic        req_reduce_len = 1'b0;
  logic        burst_valid;
  logic        burst_ready = 1'b0;
  logic [63:0] burst_addr;
  logic [7:0]  burst_len;
  logic [31:0] burst_bytes;
  logic        burst_first;
  logic        burst_last;
  logic        err_valid;
  logic [1:0]  err_type;
  logic        busy;

  int passed = 0;
  int total  = 0;
  burst_t exp_q[$];

  idma_burst_splitter #(
    .AddrWidth(64), .DataWidth(64), .TFLenWidth(32), .PageSize(4096)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_length_i(req_length),
    .req_protocol_i(req_protocol), .req_max_llen_i(req_max_llen),
    .req_reduce_len_i(req_reduce_len),
    .burst_valid_o(burst_valid), .burst_ready_i(burst_ready),
    .burst_addr_o(burst_addr), .burst_len_o(burst_len),
    .burst_bytes_o(burst_bytes), .burst_first_o(burst_first),
    .burst_last_o(burst_last),
    .err_valid_o(err_valid), .err_type_o(err_type), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: list of bursts for a transfer, from the legality rules directly.
  function automatic void model(input logic [63:0] addr, input logic [31:0] len,
                                input logic [1:0] prot, input logic [2:0] llen,
                                input logic red);
    longint unsigned rem, off, maxb, cap_beat, cap_page, nb;
    logic [63:0] a;
    logic first;
    burst_t b;
    exp_q.delete();
    rem = 64'(len);
    a = addr;
    first = 1'b1;
    while (rem > 0) begin
      off = a % 8;
      if (prot == 2'd0) maxb = (red && ((64'd1 << llen) < 256)) ? (64'd1 << llen) : 256;
      else maxb = 1;
      cap_beat = maxb * 8 - off;
      cap_page = 4096 - (a % 4096);
      nb = rem;
      if (cap_beat < nb) nb = cap_beat;
      if (cap_page < nb) nb = cap_page;
      b.addr  = a;
      b.len   = 8'((off + nb - 1) / 8);
      b.bytes = 32'(nb);
      b.first = first;
      b.last  = (nb == rem);
      exp_q.push_back(b);
      a = a + nb;
      rem = rem - nb;
      first = 1'b0;
    end
  endfunction

  function automatic burst_t mk(input logic [63:0] a, input logic [7:0] l,
                                input logic [31:0] n, input logic f, input logic la);
    burst_t b;
    b.addr = a; b.len = l; b.bytes = n; b.first = f; b.last = la;
    return b;
  endfunction

  task automatic drive_req(input logic [63:0] addr, input logic [31:0] len,
                           input logic [1:0] prot, input logic [2:0] llen, input logic red);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_idle got=%b want=1", req_ready);
    else passed++;
    req_valid = 1'b1; req_addr = addr; req_length = len;
    req_protocol = prot; req_max_llen = llen; req_reduce_len = red;
  endtask

  // Issues a request and consumes the bursts checking them against exp_q.
  // mode 0: always ready; mode 1: random ready. stall: presentations forced not-ready.
  task automatic run_xfer(input string name, input logic [63:0] addr, input logic [31:0] len,
                          input logic [1:0] prot, input logic [2:0] llen, input logic red,
                          input int mode, input int stall);
    int idx, cyc, pres;
    burst_t got;
    drive_req(addr, len, prot, llen, red);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (burst_valid !== 1'b1) $display("FAIL %s first_burst_latency valid got=%b want=1", name, burst_valid);
    else passed++;
    idx = 0; cyc = 0; pres = 0;
    while (idx < exp_q.size() && cyc < 20000) begin
      if (burst_valid === 1'b1) begin
        got = {burst_addr, burst_len, burst_bytes, burst_first, burst_last};
        total++;
        if (got !== exp_q[idx] || busy !== 1'b1 || err_valid !== 1'b0 || req_ready !== 1'b0)
          $display("FAIL %s burst%0d got addr=%h len=%0d bytes=%0d f=%b l=%b busy=%b err=%b rdy=%b want addr=%h len=%0d bytes=%0d f=%b l=%b busy=1 err=0 rdy=0",
                   name, idx, burst_addr, burst_len, burst_bytes, burst_first, burst_last,
                   busy, err_valid, req_ready, exp_q[idx].addr, exp_q[idx].len,
                   exp_q[idx].bytes, exp_q[idx].first, exp_q[idx].last);
        else passed++;
        if (pres < stall) burst_ready = 1'b0;
        else if (mode == 1) burst_ready = 1'($urandom_range(0, 1));
        else burst_ready = 1'b1;
        pres++;
        if (burst_ready) idx++;
      end else begin
        burst_ready = 1'b0;
        total++;
        $display("FAIL %s valid_dropped at burst%0d got=%b want=1", name, idx, burst_valid);
        idx = exp_q.size();
      end
      @(negedge clk);
      cyc++;
    end
    burst_ready = 1'b0;
    if (cyc >= 20000) begin
      total++;
      $display("FAIL %s timeout bursts_seen=%0d want=%0d", name, idx, exp_q.size());
    end
    total++;
    if (burst_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s end_idle got valid=%b rdy=%b busy=%b want 0/1/0", name, burst_valid, req_ready, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || burst_valid !== 1'b0 || burst_first !== 1'b0 ||
        burst_last !== 1'b0 || err_valid !== 1'b0 || err_type !== 2'b00 || busy !== 1'b0 ||
        burst_addr !== 64'd0 || burst_bytes !== 32'd0 || burst_len !== 8'd0)
      $display("FAIL reset_state got rdy=%b v=%b f=%b l=%b err=%b et=%b busy=%b addr=%h bytes=%0d len=%0d want 1/0/0/0/0/00/0/0/0/0",
               req_ready, burst_valid, burst_first, burst_last, err_valid, err_type, busy,
               burst_addr, burst_bytes, burst_len);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    exp_q.delete();
    exp_q.push_back(mk(64'h0FF8, 8'd0, 32'd8, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h1000, 8'd0, 32'd8, 1'b0, 1'b1));
    run_xfer("axi_page_cross", 64'h0FF8, 32'd16, 2'd0, 3'd0, 1'b0, 0, 0);
    exp_q.delete();
    exp_q.push_back(mk(64'h0000, 8'd255, 32'd2048, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h0800, 8'd255, 32'd2048, 1'b0, 1'b1));
    run_xfer("axi_full_page", 64'h0000, 32'd4096, 2'd0, 3'd0, 1'b0, 0, 0);
    exp_q.delete();
    exp_q.push_back(mk(64'h0004, 8'd3, 32'd28, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h0020, 8'd1, 32'd12, 1'b0, 1'b1));
    run_xfer("axi_reduce", 64'h0004, 32'd40, 2'd0, 3'd2, 1'b1, 0, 0);
    exp_q.delete();
    exp_q.push_back(mk(64'h0003, 8'd0, 32'd5, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h0008, 8'd0, 32'd5, 1'b0, 1'b1));
    run_xfer("obi_unaligned", 64'h0003, 32'd10, 2'd2, 3'd0, 1'b0, 0, 0);
    exp_q.delete();
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 32'd16, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h0000, 8'd1, 32'd16, 1'b0, 1'b1));
    run_xfer("addr_wrap", 64'hFFFF_FFFF_FFFF_FFF0, 32'd32, 2'd0, 3'd0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_len();
    drive_req(64'h1234, 32'd0, 2'd0, 3'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (err_valid !== 1'b1 || err_type !== 2'b10 || burst_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL zero_len_pulse got err=%b type=%b valid=%b rdy=%b want 1/10/0/1", err_valid, err_type, burst_valid, req_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (err_valid !== 1'b0 || err_type !== 2'b00 || burst_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL zero_len_one_cycle got err=%b type=%b valid=%b rdy=%b want 0/00/0/1", err_valid, err_type, burst_valid, req_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    exp_q.push_back(mk(64'h0000, 8'd255, 32'd2048, 1'b1, 1'b0));
    exp_q.push_back(mk(64'h0800, 8'd255, 32'd2048, 1'b0, 1'b1));
    run_xfer("backpressure", 64'h0000, 32'd4096, 2'd0, 3'd0, 1'b0, 0, 5);
  endtask

  task automatic test_reset_mid();
    drive_req(64'h0000, 32'd4096, 2'd0, 3'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (burst_valid !== 1'b1) $display("FAIL reset_mid_pre valid got=%b want=1", burst_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (burst_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || err_valid !== 1'b0 ||
        burst_first !== 1'b0 || burst_last !== 1'b0)
      $display("FAIL reset_mid got v=%b rdy=%b busy=%b err=%b f=%b l=%b want 0/1/0/0/0/0",
               burst_valid, req_ready, busy, err_valid, burst_first, burst_last);
    else passed++;
    @(negedge clk);
    total++;
    if (burst_valid !== 1'b0 || err_valid !== 1'b0)
      $display("FAIL reset_mid_after got v=%b err=%b want 0/0", burst_valid, err_valid);
    else passed++;
    model(64'h0FF8, 32'd16, 2'd0, 3'd0, 1'b0);
    run_xfer("after_reset", 64'h0FF8, 32'd16, 2'd0, 3'd0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] l;
    logic [1:0]  p;
    logic [2:0]  ll;
    logic        r;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
      p  = 2'($urandom_range(0, 2));
      ll = 3'($urandom_range(0, 7));
      r  = 1'($urandom_range(0, 1));
      if (p == 2'd0) l = 32'($urandom_range(1, 9000));
      else l = 32'($urandom_range(1, 300));
      model(a, l, p, ll, r);
      run_xfer("random", a, l, p, ll, r, 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_zero_len();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
